// File: rtl/round_robin_arbiter_n_pkg.sv
// Shared types and limits for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  localparam int MAX_N = 16;

endpackage

// File: rtl/round_robin_arbiter_n_picker.sv
// Rotated first-set search: scans req starting at ptr and wrapping at N-1.
module rr_priority_picker #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  int              pos;
  logic [IDXW-1:0] pos_idx;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < N; i++) begin
      // ptr is always < N, so a single subtraction keeps pos in range.
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      pos_idx = IDXW'(pos);
      if (!found && req[pos_idx]) begin
        onehot[pos_idx] = 1'b1;
        idx             = pos_idx;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with transaction locking until ready && last,
// or until the locked requester drops its request.
module round_robin_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    requests,
  input  logic            ready,
  input  logic            last,
  output logic [N-1:0]    grants,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  arb_state_t      state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] lk;
  logic [N-1:0]    pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic            lk_held;

  // Explicit wrap so ptr stays below N even when N is not a power of two.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  rr_priority_picker #(
    .N    (N),
    .IDXW (IDXW)
  ) u_picker (
    .req    (requests),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign lk_held = requests[lk];

  always_comb begin
    grants    = '0;
    grant_idx = '0;
    if (rst) begin
      if (state == IDLE) begin
        grants    = pick_onehot;
        grant_idx = pick_idx;
      end else if (lk_held) begin
        grants[lk] = 1'b1;
        grant_idx  = lk;
      end
    end
  end

  assign grant_valid = |grants;

  // An abort (locked requester drops) advances ptr exactly like a completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      lk    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            if (ready && last) begin
              ptr <= next_idx(pick_idx);
            end else begin
              state <= LOCKED;
              lk    <= pick_idx;
            end
          end
        end
        LOCKED: begin
          if (!lk_held || (ready && last)) begin
            state <= IDLE;
            ptr   <= next_idx(lk);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Bench for round_robin_arbiter_n at N=2, 3 and 4 against a behavioural model
// plus hand-computed directed vectors.
module tb_round_robin_arbiter_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b1;
  logic       last = 1'b1;
  logic [1:0] req2 = '1;
  logic [2:0] req3 = '1;
  logic [3:0] req4 = '1;
  logic [1:0] grants2;
  logic [2:0] grants3;
  logic [3:0] grants4;
  logic [0:0] idx2;
  logic [1:0] idx3;
  logic [1:0] idx4;
  logic       valid2, valid3, valid4;

  int total = 0;
  int bad   = 0;

  int n_of      [3] = '{2, 3, 4};
  int m_ptr     [3] = '{0, 0, 0};
  int m_lk      [3] = '{0, 0, 0};
  bit m_locked  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  round_robin_arbiter_n #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .requests(req2), .ready(ready), .last(last),
    .grants(grants2), .grant_idx(idx2), .grant_valid(valid2)
  );
  round_robin_arbiter_n #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .requests(req3), .ready(ready), .last(last),
    .grants(grants3), .grant_idx(idx3), .grant_valid(valid3)
  );
  round_robin_arbiter_n #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .requests(req4), .ready(ready), .last(last),
    .grants(grants4), .grant_idx(idx4), .grant_valid(valid4)
  );

  function automatic logic [15:0] req_of(input int k);
    case (k)
      0:       return {14'b0, req2};
      1:       return {13'b0, req3};
      default: return {12'b0, req4};
    endcase
  endfunction

  function automatic logic [15:0] dut_grants(input int k);
    case (k)
      0:       return {14'b0, grants2};
      1:       return {13'b0, grants3};
      default: return {12'b0, grants4};
    endcase
  endfunction

  function automatic int dut_idx(input int k);
    case (k)
      0:       return int'(idx2);
      1:       return int'(idx3);
      default: return int'(idx4);
    endcase
  endfunction

  function automatic logic dut_valid(input int k);
    case (k)
      0:       return valid2;
      1:       return valid3;
      default: return valid4;
    endcase
  endfunction

  // Owner of the bus this cycle per the arbitration rules, or -1 for none.
  function automatic int winner(input int k);
    logic [15:0] r;
    int          j;
    r = req_of(k);
    if (!rst) return -1;
    if (m_locked[k]) return r[m_lk[k][3:0]] ? m_lk[k] : -1;
    for (int i = 0; i < n_of[k]; i++) begin
      j = (m_ptr[k] + i) % n_of[k];
      if (r[j[3:0]]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_ptr[k]    = 0;
        m_lk[k]     = 0;
        m_locked[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        w = winner(k);
        if (m_locked[k]) begin
          if (w < 0 || (ready && last)) begin
            m_locked[k] = 0;
            m_ptr[k]    = (m_lk[k] + 1) % n_of[k];
          end
        end else if (w >= 0) begin
          if (ready && last) begin
            m_ptr[k] = (w + 1) % n_of[k];
          end else begin
            m_locked[k] = 1;
            m_lk[k]     = w;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int          w;
    logic [15:0] exp_g;
    for (int k = 0; k < 3; k++) begin
      w     = winner(k);
      exp_g = (w < 0) ? 16'h0 : (16'h1 << w);
      total++;
      if (dut_grants(k) !== exp_g) begin
        bad++;
        $display("[TB] FAIL model_grants n=%0d t=%0t: got=%b want=%b", n_of[k], $time, dut_grants(k), exp_g);
      end
      total++;
      if (dut_idx(k) != ((w < 0) ? 0 : w)) begin
        bad++;
        $display("[TB] FAIL model_idx n=%0d t=%0t: got=%0d want=%0d", n_of[k], $time, dut_idx(k), (w < 0) ? 0 : w);
      end
      total++;
      if (dut_valid(k) !== (w >= 0)) begin
        bad++;
        $display("[TB] FAIL model_valid n=%0d t=%0t: got=%b want=%b", n_of[k], $time, dut_valid(k), (w >= 0));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] r2, input logic [2:0] r3, input logic [3:0] r4,
                               input logic rdy, input logic lst);
    @(posedge clk);
    #1;
    req2  = r2;
    req3  = r3;
    req4  = r4;
    ready = rdy;
    last  = lst;
  endtask

  task automatic checkOutput(input string name, input int k, input logic [15:0] expected);
    logic [15:0] got;
    got = dut_grants(k);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s: grants=%b expected=%b", name, got, expected);
    end
  endtask

  logic [1:0] seq2_in  [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
  logic [1:0] seq2_exp [10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
  int         seq4_idx [5]  = '{0, 1, 2, 3, 0};

  initial begin
    $display("[TB] start");
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_n2", 0, 16'h0);
    checkOutput("reset_n3", 1, 16'h0);
    checkOutput("reset_n4", 2, 16'h0);

    applyStimulus(2'b00, 3'b000, 4'b0000, 1'b1, 1'b1);
    rst = 1'b1;

    // N=2 contention sequence with ready=last=1
    for (int i = 0; i < 10; i++) begin
      applyStimulus(seq2_in[i], 3'b000, 4'b0000, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("n2_seq%0d", i), 0, {14'b0, seq2_exp[i]});
    end

    // N=4 all requesting: strict rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 3'b000, 4'b1111, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("n4_rot%0d", i), 2, 16'h1 << seq4_idx[i]);
    end

    // ptr=1: requester 1 locks for three beats then completes
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 3'b000, 4'b0110, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("n4_lock%0d", i), 2, 16'b0010);
    end
    applyStimulus(2'b00, 3'b000, 4'b0110, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n4_lock_done", 2, 16'b0010);
    applyStimulus(2'b00, 3'b000, 4'b0110, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("n4_next_after_lock", 2, 16'b0100);

    // Locked at 2, requester 2 drops: abort cycle then ptr=3
    applyStimulus(2'b00, 3'b000, 4'b1001, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n4_abort", 2, 16'b0000);
    applyStimulus(2'b00, 3'b000, 4'b1001, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n4_after_abort", 2, 16'b1000);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 3'b000, 4'b0010, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("n4_lone%0d", i), 2, 16'b0010);
    end

    // Reach lock at 3, then reset mid-lock
    applyStimulus(2'b00, 3'b000, 4'b0100, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n4_to_ptr3", 2, 16'b0100);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 3'b000, 4'b1111, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("n4_lock3_%0d", i), 2, 16'b1000);
    end
    #1;
    rst = 1'b0;
    #1;
    checkOutput("n4_rst_immediate", 2, 16'h0);
    applyStimulus(2'b11, 3'b111, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n4_rst_hold", 2, 16'h0);
    checkOutput("n2_rst_hold", 0, 16'h0);
    applyStimulus(2'b00, 3'b000, 4'b1111, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("n4_after_rst", 2, 16'b0001);

    // N=3 wrap from ptr=2
    applyStimulus(2'b00, 3'b010, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n3_to_ptr2", 1, 16'b010);
    applyStimulus(2'b00, 3'b111, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n3_wrap_a", 1, 16'b100);
    applyStimulus(2'b00, 3'b111, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("n3_wrap_b", 1, 16'b001);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'($urandom), 3'($urandom), 4'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    applyStimulus(2'b00, 3'b000, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
